// File: rtl/adc_result_reader.sv
// ADC result reader: config registers, conv_finished synchronizer with edge-detected
// capture, and a small result FIFO with occupancy, sticky overflow and sample count.
module adc_result_reader #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable_in,
  input  logic                          cfg_we_in,
  input  logic                          cfg_sel_in,
  input  logic [15:0]                   cfg_data_in,
  output logic [15:0]                   config_1_out,
  output logic [15:0]                   config_2_out,
  output logic                          adc_rst_n_out,
  input  logic [15:0]                   result_in,
  input  logic                          conv_finished_in,
  output logic                          rd_valid_out,
  input  logic                          rd_ready_in,
  output logic [15:0]                   rd_data_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out,
  output logic                          overflow_out,
  input  logic                          clear_in,
  output logic [15:0]                   sample_cnt_out
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 16;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DW-1:0]          cfg1_q, cfg1_d;
  logic [DW-1:0]          cfg2_q, cfg2_d;
  logic                   en_q;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   prev_q, prev_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic [DW-1:0]          smp_q, smp_d;
  logic [DW-1:0]          mem_q [FIFO_DEPTH];

  logic capture_c;
  logic cap_en_c;
  logic full_c;
  logic pop_c;
  logic push_c;
  logic drop_c;

  // Next-state logic: config, synchronizer, edge detect and FIFO bookkeeping
  always_comb begin
    cfg1_d   = cfg1_q;
    cfg2_d   = cfg2_q;
    sync_d   = {sync_q[SYNC_STAGES-2:0], conv_finished_in};
    fill_d   = {fill_q[SYNC_STAGES-2:0], 1'b1};
    // Hold the edge detector's history high until the chain has refilled after reset,
    // so a level already high at reset release is not seen as a new rising edge.
    prev_d   = fill_q[SYNC_STAGES-1] ? sync_q[SYNC_STAGES-1] : 1'b1;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    smp_d    = smp_q;

    capture_c = fill_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES-1] & ~prev_q;
    cap_en_c  = capture_c & en_q & ~clear_in;
    full_c    = (count_q == FULL_CNT);
    pop_c     = valid_q & rd_ready_in & ~clear_in;
    push_c    = cap_en_c & (~full_c | pop_c);
    drop_c    = cap_en_c & full_c & ~pop_c;

    if (cfg_we_in) begin
      if (cfg_sel_in) cfg2_d = cfg_data_in;
      else            cfg1_d = cfg_data_in;
    end

    if (clear_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      smp_d    = '0;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        smp_d    = smp_q + DW'(1);
      end
      if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push_c && !pop_c)      count_d = count_q + CW'(1);
      else if (!push_c && pop_c) count_d = count_q - CW'(1);
      if (drop_c) ovf_d = 1'b1;
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg1_q   <= '0;
      cfg2_q   <= '0;
      en_q     <= 1'b0;
      sync_q   <= '0;
      fill_q   <= '0;
      prev_q   <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      smp_q    <= '0;
    end else begin
      cfg1_q   <= cfg1_d;
      cfg2_q   <= cfg2_d;
      en_q     <= enable_in;
      sync_q   <= sync_d;
      fill_q   <= fill_d;
      prev_q   <= prev_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      smp_q    <= smp_d;
    end
  end

  // Result storage; contents are only meaningful behind the pointers
  always_ff @(posedge clk) begin
    if (!rst && push_c) mem_q[wr_ptr_q] <= result_in;
  end

  assign config_1_out   = cfg1_q;
  assign config_2_out   = cfg2_q;
  assign adc_rst_n_out  = en_q;
  assign rd_valid_out   = valid_q;
  assign rd_data_out    = mem_q[rd_ptr_q];
  assign count_out      = count_q;
  assign overflow_out   = ovf_q;
  assign sample_cnt_out = smp_q;

endmodule

// File: tb/tb_adc_result_reader.sv
// Directed bench for adc_result_reader (FIFO_DEPTH=4, SYNC_STAGES=2).
module tb_adc_result_reader;

  logic        clk;
  logic        rst;
  logic        enable_in;
  logic        cfg_we_in;
  logic        cfg_sel_in;
  logic [15:0] cfg_data_in;
  logic [15:0] config_1_out;
  logic [15:0] config_2_out;
  logic        adc_rst_n_out;
  logic [15:0] result_in;
  logic        conv_finished_in;
  logic        rd_valid_out;
  logic        rd_ready_in;
  logic [15:0] rd_data_out;
  logic [2:0]  count_out;
  logic        overflow_out;
  logic        clear_in;
  logic [15:0] sample_cnt_out;

  int n_cmp = 0;
  int n_bad = 0;

  adc_result_reader #(.FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_in        (enable_in),
    .cfg_we_in        (cfg_we_in),
    .cfg_sel_in       (cfg_sel_in),
    .cfg_data_in      (cfg_data_in),
    .config_1_out     (config_1_out),
    .config_2_out     (config_2_out),
    .adc_rst_n_out    (adc_rst_n_out),
    .result_in        (result_in),
    .conv_finished_in (conv_finished_in),
    .rd_valid_out     (rd_valid_out),
    .rd_ready_in      (rd_ready_in),
    .rd_data_out      (rd_data_out),
    .count_out        (count_out),
    .overflow_out     (overflow_out),
    .clear_in         (clear_in),
    .sample_cnt_out   (sample_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Conversion strobe: high 3 cycles (push on the 3rd edge), then low 2 cycles
  task automatic conv_pulse(input logic [15:0] d);
    result_in = d;
    conv_finished_in = 1'b1;
    repeat (3) tick();
    conv_finished_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic do_clear();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if (config_1_out !== 16'h0000) begin n_bad++; $display("FAIL rst_cfg1 got=%h exp=0000", config_1_out); end
    n_cmp++; if (config_2_out !== 16'h0000) begin n_bad++; $display("FAIL rst_cfg2 got=%h exp=0000", config_2_out); end
    n_cmp++; if (adc_rst_n_out !== 1'b0) begin n_bad++; $display("FAIL rst_adc_rst_n got=%b exp=0", adc_rst_n_out); end
    n_cmp++; if (count_out !== 3'd0) begin n_bad++; $display("FAIL rst_count got=%0d exp=0", count_out); end
    n_cmp++; if (rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", rd_valid_out); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%b exp=0", overflow_out); end
    n_cmp++; if (sample_cnt_out !== 16'h0000) begin n_bad++; $display("FAIL rst_sample got=%h exp=0000", sample_cnt_out); end
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_config();
    cfg_we_in = 1'b1; cfg_sel_in = 1'b0; cfg_data_in = 16'h0019;
    tick();
    n_cmp++; if (config_1_out !== 16'h0019) begin n_bad++; $display("FAIL cfg1_write got=%h exp=0019", config_1_out); end
    n_cmp++; if (config_2_out !== 16'h0000) begin n_bad++; $display("FAIL cfg2_untouched got=%h exp=0000", config_2_out); end
    cfg_sel_in = 1'b1; cfg_data_in = 16'hA5A5;
    tick();
    cfg_we_in = 1'b0; cfg_data_in = 16'h1234;
    n_cmp++; if (config_1_out !== 16'h0019) begin n_bad++; $display("FAIL cfg1_kept got=%h exp=0019", config_1_out); end
    n_cmp++; if (config_2_out !== 16'hA5A5) begin n_bad++; $display("FAIL cfg2_write got=%h exp=a5a5", config_2_out); end
    tick();
    n_cmp++; if (config_1_out !== 16'h0019) begin n_bad++; $display("FAIL cfg1_no_we got=%h exp=0019", config_1_out); end
  endtask

  task automatic test_single_capture();
    enable_in = 1'b1;
    tick();
    n_cmp++; if (adc_rst_n_out !== 1'b1) begin n_bad++; $display("FAIL adc_rst_n_en got=%b exp=1", adc_rst_n_out); end
    result_in = 16'h0ABC;
    conv_finished_in = 1'b1;
    repeat (2) tick();
    n_cmp++; if (rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL cap_early got=%b exp=0", rd_valid_out); end
    tick();
    n_cmp++; if (rd_valid_out !== 1'b1) begin n_bad++; $display("FAIL cap_valid got=%b exp=1", rd_valid_out); end
    n_cmp++; if (rd_data_out !== 16'h0ABC) begin n_bad++; $display("FAIL cap_data got=%h exp=0abc", rd_data_out); end
    n_cmp++; if (sample_cnt_out !== 16'd1) begin n_bad++; $display("FAIL cap_sample got=%0d exp=1", sample_cnt_out); end
    n_cmp++; if (count_out !== 3'd1) begin n_bad++; $display("FAIL cap_count got=%0d exp=1", count_out); end
    conv_finished_in = 1'b0;
    repeat (2) tick();
    n_cmp++; if (count_out !== 3'd1) begin n_bad++; $display("FAIL cap_once got=%0d exp=1", count_out); end
    rd_ready_in = 1'b1;
    tick();
    rd_ready_in = 1'b0;
    n_cmp++; if (count_out !== 3'd0 || rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL cap_pop got=%0d/%b exp=0/0", count_out, rd_valid_out); end
  endtask

  task automatic test_overflow();
    do_clear();
    n_cmp++; if (sample_cnt_out !== 16'd0) begin n_bad++; $display("FAIL ovf_preclear got=%0d exp=0", sample_cnt_out); end
    for (int i = 1; i <= 5; i++) conv_pulse(16'(i));
    n_cmp++; if (count_out !== 3'd4) begin n_bad++; $display("FAIL ovf_count got=%0d exp=4", count_out); end
    n_cmp++; if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%b exp=1", overflow_out); end
    n_cmp++; if (sample_cnt_out !== 16'd4) begin n_bad++; $display("FAIL ovf_sample got=%0d exp=4", sample_cnt_out); end
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (rd_valid_out !== 1'b1 || rd_data_out !== 16'(i)) begin n_bad++; $display("FAIL ovf_read%0d got=%b/%h exp=1/%h", i, rd_valid_out, rd_data_out, 16'(i)); end
      rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
    end
    n_cmp++; if (count_out !== 3'd0) begin n_bad++; $display("FAIL ovf_drained got=%0d exp=0", count_out); end
    n_cmp++; if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b exp=1", overflow_out); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    for (int i = 1; i <= 4; i++) conv_pulse(16'h0010 + 16'(i));
    result_in = 16'h0015;
    conv_finished_in = 1'b1;
    repeat (2) tick();
    rd_ready_in = 1'b1;
    tick();
    rd_ready_in = 1'b0;
    conv_finished_in = 1'b0;
    repeat (2) tick();
    n_cmp++; if (count_out !== 3'd4) begin n_bad++; $display("FAIL b2b_count got=%0d exp=4", count_out); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf got=%b exp=0", overflow_out); end
    n_cmp++; if (sample_cnt_out !== 16'd5) begin n_bad++; $display("FAIL b2b_sample got=%0d exp=5", sample_cnt_out); end
    for (int i = 2; i <= 5; i++) begin
      n_cmp++; if (rd_data_out !== 16'h0010 + 16'(i)) begin n_bad++; $display("FAIL b2b_read%0d got=%h exp=%h", i, rd_data_out, 16'h0010 + 16'(i)); end
      rd_ready_in = 1'b1;
      tick();
      rd_ready_in = 1'b0;
    end
    rd_ready_in = 1'b1;
    tick();
    rd_ready_in = 1'b0;
    n_cmp++; if (count_out !== 3'd0 || rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL empty_pop got=%0d/%b exp=0/0", count_out, rd_valid_out); end
  endtask

  task automatic test_disabled();
    enable_in = 1'b0;
    tick();
    n_cmp++; if (adc_rst_n_out !== 1'b0) begin n_bad++; $display("FAIL dis_adc_rst_n got=%b exp=0", adc_rst_n_out); end
    conv_pulse(16'h0BAD);
    n_cmp++; if (count_out !== 3'd0) begin n_bad++; $display("FAIL dis_count got=%0d exp=0", count_out); end
    n_cmp++; if (sample_cnt_out !== 16'd5) begin n_bad++; $display("FAIL dis_sample got=%0d exp=5", sample_cnt_out); end
    enable_in = 1'b1;
    tick();
  endtask

  task automatic test_clear_rst();
    do_clear();
    for (int i = 1; i <= 5; i++) conv_pulse(16'h0020 + 16'(i));
    rd_ready_in = 1'b1;
    tick();
    rd_ready_in = 1'b0;
    n_cmp++; if (count_out !== 3'd3 || overflow_out !== 1'b1) begin n_bad++; $display("FAIL clr_pre got=%0d/%b exp=3/1", count_out, overflow_out); end
    do_clear();
    n_cmp++; if (count_out !== 3'd0 || rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL clr_count got=%0d/%b exp=0/0", count_out, rd_valid_out); end
    n_cmp++; if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL clr_ovf got=%b exp=0", overflow_out); end
    n_cmp++; if (sample_cnt_out !== 16'd0) begin n_bad++; $display("FAIL clr_sample got=%0d exp=0", sample_cnt_out); end
    n_cmp++; if (config_1_out !== 16'h0019 || config_2_out !== 16'hA5A5) begin n_bad++; $display("FAIL clr_cfg got=%h/%h exp=0019/a5a5", config_1_out, config_2_out); end
    // Capture edge coinciding with clear is discarded
    result_in = 16'h0031;
    conv_finished_in = 1'b1;
    repeat (2) tick();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    conv_finished_in = 1'b0;
    repeat (2) tick();
    n_cmp++; if (count_out !== 3'd0 || sample_cnt_out !== 16'd0) begin n_bad++; $display("FAIL clr_cap got=%0d/%0d exp=0/0", count_out, sample_cnt_out); end
    conv_pulse(16'h0033);
    n_cmp++; if (count_out !== 3'd1 || rd_data_out !== 16'h0033) begin n_bad++; $display("FAIL clr_after got=%0d/%h exp=1/0033", count_out, rd_data_out); end
    // Reset wins over a concurrent config write; conv held high across release
    rst = 1'b1;
    cfg_we_in = 1'b1; cfg_sel_in = 1'b0; cfg_data_in = 16'hFFFF;
    result_in = 16'h0077;
    conv_finished_in = 1'b1;
    tick();
    n_cmp++; if (config_1_out !== 16'h0000 || config_2_out !== 16'h0000) begin n_bad++; $display("FAIL rst2_cfg got=%h/%h exp=0000/0000", config_1_out, config_2_out); end
    n_cmp++; if (count_out !== 3'd0 || rd_valid_out !== 1'b0 || overflow_out !== 1'b0) begin n_bad++; $display("FAIL rst2_fifo got=%0d/%b/%b exp=0/0/0", count_out, rd_valid_out, overflow_out); end
    n_cmp++; if (sample_cnt_out !== 16'd0 || adc_rst_n_out !== 1'b0) begin n_bad++; $display("FAIL rst2_misc got=%0d/%b exp=0/0", sample_cnt_out, adc_rst_n_out); end
    cfg_we_in = 1'b0;
    tick();
    rst = 1'b0;
    repeat (6) tick();
    n_cmp++; if (count_out !== 3'd0 || sample_cnt_out !== 16'd0) begin n_bad++; $display("FAIL rst2_held_conv got=%0d/%0d exp=0/0", count_out, sample_cnt_out); end
    n_cmp++; if (adc_rst_n_out !== 1'b1) begin n_bad++; $display("FAIL rst2_adc_rst_n got=%b exp=1", adc_rst_n_out); end
    conv_finished_in = 1'b0;
    repeat (2) tick();
    conv_finished_in = 1'b1;
    repeat (3) tick();
    n_cmp++; if (count_out !== 3'd1 || rd_data_out !== 16'h0077) begin n_bad++; $display("FAIL rst2_recapture got=%0d/%h exp=1/0077", count_out, rd_data_out); end
    conv_finished_in = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    enable_in = 1'b0;
    cfg_we_in = 1'b0;
    cfg_sel_in = 1'b0;
    cfg_data_in = 16'h0000;
    result_in = 16'h0000;
    conv_finished_in = 1'b0;
    rd_ready_in = 1'b0;
    clear_in = 1'b0;
    test_reset();
    test_config();
    test_single_capture();
    test_overflow();
    test_back_to_back();
    test_disabled();
    test_clear_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
